puf_eval_sequencer: RTL and testbench

Controller that drives the on-chip arbiter PUF (8-stage mux delay line plus arbiter flop). It generates a run of challenges from a seed and fires the race pulse for each one. Each challenge is evaluated VOTE_COUNT times, the synchronised one-bit responses are majority-voted, and the voted bits are packed into a response word. The word is returned over a valid/ready handshake. The block sits between the top-level I/O wrapper and the arbiterpuf instance, and it replaces the free-running use of clk as the race pulse.

---
 rtl/puf_eval_sequencer_if.sv | 35 +++
 rtl/puf_eval_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_puf_eval_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/puf_eval_sequencer_if.sv
// -----------------------------------------------------------------------------
// puf_eval_sequencer_if
// Request/response bundle between the I/O wrapper and the PUF evaluation
// sequencer.
//   i_start      : request one response word (wrapper -> sequencer)
//   i_seed       : first challenge of the run, sampled with an accepted i_start
//   o_busy       : run in progress (sequencer -> wrapper)
//   o_resp_word  : majority-voted response word
//   o_resp_valid : response word available
//   i_resp_ready : wrapper accepts the word
//   o_unstable   : at least one bit of the word had non-unanimous votes
// Modports: master = wrapper side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface puf_eval_sequencer_if #(
    parameter int C_LENGTH  = 8,
    parameter int RESP_BITS = 8
);
    logic                 i_start;
    logic [C_LENGTH-1:0]  i_seed;
    logic                 o_busy;
    logic [RESP_BITS-1:0] o_resp_word;
    logic                 o_resp_valid;
    logic                 i_resp_ready;
    logic                 o_unstable;

    modport master (
        output i_start, i_seed, i_resp_ready,
        input  o_busy, o_resp_word, o_resp_valid, o_unstable
    );

    modport slave (
        input  i_start, i_seed, i_resp_ready,
        output o_busy, o_resp_word, o_resp_valid, o_unstable
    );
endinterface

// File: rtl/puf_eval_sequencer.sv
// -----------------------------------------------------------------------------
// puf_eval_sequencer
// Drives an arbiter PUF: walks RESP_BITS consecutive challenges starting at a
// seed, fires one race pulse per evaluation, evaluates every challenge
// VOTE_COUNT times, majority-votes the synchronised responses and returns the
// packed word over a valid/ready handshake.
// Ports:
//   clk, rst_n   : system clock, asynchronous active-low reset
//   bus          : request/response bundle (slave modport)
//   o_challenge  : challenge to the delay-line mux selects
//   o_pulse      : race launch pulse into the delay line
//   i_response   : arbiter flop output, asynchronous to clk
// Each evaluation spends SETTLE_CYCLES with the pulse low, CAPTURE_CYCLES with
// the pulse high, then 2 sample cycles with the pulse still high; the response
// is taken on the last sample cycle.
// -----------------------------------------------------------------------------
module puf_eval_sequencer #(
    parameter int C_LENGTH       = 8,
    parameter int RESP_BITS      = 8,
    parameter int VOTE_COUNT     = 5,
    parameter int SETTLE_CYCLES  = 2,
    parameter int CAPTURE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    puf_eval_sequencer_if.slave bus,
    output logic [C_LENGTH-1:0] o_challenge,
    output logic                o_pulse,
    input  logic                i_response
);

    // Phase counter must cover the longest timed state (SAMPLE is 2 cycles).
    localparam int CNT_MAX = (SETTLE_CYCLES > CAPTURE_CYCLES)
                           ? ((SETTLE_CYCLES > 2) ? SETTLE_CYCLES : 2)
                           : ((CAPTURE_CYCLES > 2) ? CAPTURE_CYCLES : 2);
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int VOTE_W  = $clog2(VOTE_COUNT + 1);
    localparam int BIT_W   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    localparam logic [CNT_W-1:0]  SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CAPTURE_LAST = CNT_W'(CAPTURE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SAMPLE_LAST  = CNT_W'(1);
    localparam logic [VOTE_W-1:0] VOTE_TOTAL   = VOTE_W'(VOTE_COUNT);
    localparam logic [VOTE_W-1:0] VOTE_HALF    = VOTE_W'(VOTE_COUNT / 2);
    localparam logic [BIT_W-1:0]  BIT_LAST     = BIT_W'(RESP_BITS - 1);

    // Elaboration-time parameter sanity.
    if (VOTE_COUNT < 1 || VOTE_COUNT > 15 || (VOTE_COUNT % 2) == 0) begin : g_bad_vote
        $error("puf_eval_sequencer: VOTE_COUNT must be odd and in 1..15");
    end
    if (SETTLE_CYCLES < 1 || CAPTURE_CYCLES < 1) begin : g_bad_timing
        $error("puf_eval_sequencer: SETTLE_CYCLES and CAPTURE_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_LAUNCH,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     phase_cnt;
    logic [VOTE_W-1:0]    vote_cnt, ones_cnt;
    logic [VOTE_W-1:0]    vote_inc, ones_inc;
    logic [BIT_W-1:0]     bit_idx;
    logic [C_LENGTH-1:0]  chal_q;
    logic [RESP_BITS-1:0] word_q;
    logic                 unstable_q;
    logic                 pulse_q, busy_q, valid_q;
    logic [1:0]           sync_q;
    logic                 resp_sync;

    logic start_acc;
    logic phase_last;
    logic sample_now;
    logic vote_done;
    logic bit_last;

    assign resp_sync = sync_q[1];

    // -------------------------------------------------------------------------
    // Two-flop synchroniser for the arbiter output (asynchronous to clk).
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], i_response};
        end
    end

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and per-cycle decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nxt  = state;
        start_acc  = 1'b0;
        phase_last = 1'b0;
        sample_now = 1'b0;
        vote_inc   = vote_cnt + VOTE_W'(1);
        ones_inc   = ones_cnt + VOTE_W'(resp_sync);
        vote_done  = (vote_inc == VOTE_TOTAL);
        bit_last   = (bit_idx == BIT_LAST);

        case (state)
            ST_IDLE: begin
                if (bus.i_start) begin
                    start_acc = 1'b1;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                phase_last = (phase_cnt == SETTLE_LAST);
                if (phase_last) state_nxt = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                phase_last = (phase_cnt == CAPTURE_LAST);
                if (phase_last) state_nxt = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                phase_last = (phase_cnt == SAMPLE_LAST);
                sample_now = phase_last;
                if (phase_last) begin
                    state_nxt = (vote_done && bit_last) ? ST_DONE : ST_SETTLE;
                end
            end
            ST_DONE: begin
                // i_start is deliberately not looked at here.
                if (bus.i_resp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Phase counter: restarts at every state entry, idles at 0 outside the
    // timed states.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt <= '0;
        end else if (phase_last || state == ST_IDLE || state == ST_DONE) begin
            phase_cnt <= '0;
        end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs decoded from the next state, so the race pulse comes
    // straight from a flop and cannot glitch; the async reset drops it at once.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            pulse_q <= (state_nxt == ST_LAUNCH) || (state_nxt == ST_SAMPLE);
            busy_q  <= (state_nxt == ST_SETTLE) || (state_nxt == ST_LAUNCH)
                    || (state_nxt == ST_SAMPLE);
            valid_q <= (state_nxt == ST_DONE);
        end
    end

    // -------------------------------------------------------------------------
    // Vote accumulation, word packing and challenge stepping.
    // The challenge only moves on the SAMPLE->SETTLE edge, the same edge that
    // drops the pulse, so it never changes while the pulse is high.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chal_q     <= '0;
            vote_cnt   <= '0;
            ones_cnt   <= '0;
            bit_idx    <= '0;
            word_q     <= '0;
            unstable_q <= 1'b0;
        end else if (start_acc) begin
            chal_q     <= bus.i_seed;
            vote_cnt   <= '0;
            ones_cnt   <= '0;
            bit_idx    <= '0;
            unstable_q <= 1'b0;
        end else if (sample_now) begin
            if (!vote_done) begin
                vote_cnt <= vote_inc;
                ones_cnt <= ones_inc;
            end else begin
                word_q[bit_idx] <= (ones_inc > VOTE_HALF);
                if (ones_inc != '0 && ones_inc != VOTE_TOTAL) begin
                    unstable_q <= 1'b1;
                end
                vote_cnt <= '0;
                ones_cnt <= '0;
                if (!bit_last) begin
                    bit_idx <= bit_idx + BIT_W'(1);
                    chal_q  <= chal_q + C_LENGTH'(1);
                end
            end
        end
    end

    assign o_challenge      = chal_q;
    assign o_pulse          = pulse_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_resp_valid = valid_q;
    assign bus.o_resp_word  = word_q;
    assign bus.o_unstable   = unstable_q;

endmodule

// File: tb/tb_puf_eval_sequencer.sv
// -----------------------------------------------------------------------------
// tb_puf_eval_sequencer
// Self-checking bench for puf_eval_sequencer. A behavioural PUF answers each
// pulse rise with the XOR-reduce of the challenge, optionally inverted on a
// chosen challenge or by random noise. Every answer it gives is logged; the
// expected word is the per-challenge majority of that log.
// -----------------------------------------------------------------------------
module tb_puf_eval_sequencer;

    localparam int C_LENGTH       = 8;
    localparam int RESP_BITS      = 8;
    localparam int VOTE_COUNT     = 5;
    localparam int SETTLE_CYCLES  = 2;
    localparam int CAPTURE_CYCLES = 2;
    localparam int LATENCY = RESP_BITS * VOTE_COUNT * (SETTLE_CYCLES + CAPTURE_CYCLES + 2);
    localparam int BUDGET  = LATENCY + 100;

    logic                clk;
    logic                rst_n;
    logic [C_LENGTH-1:0] o_challenge;
    logic                o_pulse;
    logic                i_response;

    puf_eval_sequencer_if #(.C_LENGTH(C_LENGTH), .RESP_BITS(RESP_BITS)) bus ();

    puf_eval_sequencer #(
        .C_LENGTH      (C_LENGTH),
        .RESP_BITS     (RESP_BITS),
        .VOTE_COUNT    (VOTE_COUNT),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CAPTURE_CYCLES(CAPTURE_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .o_challenge(o_challenge),
        .o_pulse    (o_pulse),
        .i_response (i_response)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- PUF model
    logic [C_LENGTH-1:0] inv_chal  = '0;
    int                  inv_n     = 0;
    int                  inv_seen  = 0;
    int                  noise_pct = 0;
    logic                puf_r;
    logic                resp_q[$];
    logic [C_LENGTH-1:0] chal_q[$];

    always @(posedge o_pulse) begin
        puf_r = ^o_challenge;
        if (o_challenge == inv_chal) begin
            if (inv_seen < inv_n) puf_r = ~puf_r;
            inv_seen++;
        end
        if (noise_pct > 0 && $urandom_range(99) < noise_pct) puf_r = ~puf_r;
        i_response = puf_r;
        resp_q.push_back(puf_r);
        chal_q.push_back(o_challenge);
    end

    // Challenge must not move while the pulse is high.
    logic [C_LENGTH-1:0] prev_chal = '0;
    always @(negedge clk) begin
        if (rst_n && o_pulse) check("chal_stable", o_challenge, prev_chal);
        prev_chal = o_challenge;
    end

    // ------------------------------------------------------- reference model
    task automatic check_model(input logic [C_LENGTH-1:0] seed,
                               input logic [RESP_BITS-1:0] word, input logic unst);
        logic [RESP_BITS-1:0] exp_word;
        logic                 exp_unst;
        logic [C_LENGTH-1:0]  exp_chal;
        int                   ones;
        exp_word = '0;
        exp_unst = 1'b0;
        check("pulse_rises", resp_q.size(), RESP_BITS * VOTE_COUNT);
        if (resp_q.size() != RESP_BITS * VOTE_COUNT) return;
        for (int k = 0; k < RESP_BITS; k++) begin
            exp_chal = seed + C_LENGTH'(k);
            ones = 0;
            for (int v = 0; v < VOTE_COUNT; v++) begin
                check("model_chal", chal_q[k * VOTE_COUNT + v], exp_chal);
                ones += int'(resp_q[k * VOTE_COUNT + v]);
            end
            exp_word[k] = (2 * ones > VOTE_COUNT);
            if (ones != 0 && ones != VOTE_COUNT) exp_unst = 1'b1;
        end
        check("model_word", word, exp_word);
        check("model_unstable", unst, exp_unst);
    endtask

    // ------------------------------------------------------------ run a word
    task automatic run_word(input logic [C_LENGTH-1:0] seed, input int hold, input bit spam,
                            output logic [RESP_BITS-1:0] word, output logic unst);
        int lat;
        bit done;
        resp_q.delete();
        chal_q.delete();
        inv_seen = 0;
        @(negedge clk);
        bus.i_seed  = seed;
        bus.i_start = 1'b1;
        @(posedge clk);                       // edge 0
        #1;
        check("busy_after_accept", bus.o_busy, 1'b1);
        lat  = 0;
        done = 1'b0;
        while (!done && lat < BUDGET) begin
            @(negedge clk);
            bus.i_start = spam ? 1'($urandom_range(1)) : 1'b0;
            bus.i_seed  = C_LENGTH'($urandom);
            @(posedge clk);
            lat++;
            #1;
            done = bus.o_resp_valid;
        end
        check("valid_latency", lat, LATENCY);
        word = bus.o_resp_word;
        unst = bus.o_unstable;
        if (!done) begin
            bus.i_start = 1'b0;
            return;
        end
        check("busy_at_valid", bus.o_busy, 1'b0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus.i_start      = 1'($urandom_range(1));
            bus.i_resp_ready = 1'b0;
            @(posedge clk);
            #1;
            check("hold_valid", bus.o_resp_valid, 1'b1);
            check("hold_word", bus.o_resp_word, word);
            check("hold_busy", bus.o_busy, 1'b0);
        end
        @(negedge clk);
        bus.i_resp_ready = 1'b1;
        bus.i_start      = spam;              // ignored on the handshake edge
        @(posedge clk);
        #1;
        check("valid_dropped", bus.o_resp_valid, 1'b0);
        check("busy_after_ack", bus.o_busy, 1'b0);
        @(negedge clk);
        bus.i_resp_ready = 1'b0;
        bus.i_start      = 1'b0;
        @(posedge clk);
        #1;
        check("no_restart", bus.o_busy, 1'b0);
        check_model(seed, word, unst);
    endtask

    // --------------------------------------------------------------- watchdog
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ----------------------------------------------------------------- main
    logic [RESP_BITS-1:0] w;
    logic                 u;
    int                   n;

    initial begin
        rst_n            = 1'b0;
        i_response       = 1'b0;
        bus.i_start      = 1'b0;
        bus.i_seed       = '0;
        bus.i_resp_ready = 1'b0;
        #12;
        check("rst_busy", bus.o_busy, 1'b0);
        check("rst_valid", bus.o_resp_valid, 1'b0);
        check("rst_word", bus.o_resp_word, '0);
        check("rst_unstable", bus.o_unstable, 1'b0);
        check("rst_pulse", o_pulse, 1'b0);
        check("rst_chal", o_challenge, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean PUF, seed 00.
        run_word(8'h00, 0, 1'b0, w, u);
        check("seed00_word", w, 8'h96);
        check("seed00_unstable", u, 1'b0);

        // Wrapping challenge run FC..03.
        run_word(8'hFC, 2, 1'b1, w, u);
        check("seedFC_word", w, 8'h66);
        check("seedFC_unstable", u, 1'b0);

        // Two of five votes inverted on challenge 03: majority holds.
        inv_chal = 8'h03;
        inv_n    = 2;
        run_word(8'h00, 0, 1'b0, w, u);
        check("inv2_word", w, 8'h96);
        check("inv2_unstable", u, 1'b1);

        // Three of five inverted: bit 3 flips.
        inv_n = 3;
        run_word(8'h00, 0, 1'b0, w, u);
        check("inv3_word", w, 8'h9E);
        check("inv3_unstable", u, 1'b1);

        // Long hold with i_start pulses while valid, then a fresh run.
        inv_n = 0;
        run_word(8'h00, 10, 1'b1, w, u);
        check("hold_run_word", w, 8'h96);
        check("hold_run_unstable", u, 1'b0);

        // Reset during LAUNCH of bit 3 (16th pulse rise).
        resp_q.delete();
        chal_q.delete();
        @(negedge clk);
        bus.i_seed  = 8'h00;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        n = 0;
        while (resp_q.size() < 3 * VOTE_COUNT + 1 && n < BUDGET) begin
            @(posedge clk);
            n++;
        end
        #2;
        check("rstmid_reached", resp_q.size(), 3 * VOTE_COUNT + 1);
        check("rstmid_pulse_pre", o_pulse, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rstmid_pulse", o_pulse, 1'b0);
        check("rstmid_busy", bus.o_busy, 1'b0);
        check("rstmid_valid", bus.o_resp_valid, 1'b0);
        check("rstmid_word", bus.o_resp_word, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_word(8'h00, 0, 1'b0, w, u);
        check("post_rst_word", w, 8'h96);
        check("post_rst_unstable", u, 1'b0);

        // Randomised runs with noisy responses.
        for (int r = 0; r < 6; r++) begin
            noise_pct = $urandom_range(30);
            run_word(C_LENGTH'($urandom), $urandom_range(4), 1'b1, w, u);
        end
        noise_pct = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
